// File: rtl/conv_controller_cfg.sv
// Runtime-configurable KxK convolution sequencer.
// Loop order (outermost first): x, y, ch_in, ch_out, k_v, k_h.
// Advances one tap per a/b operand handshake. Drives the MAC datapath and
// the partial-sum memory, and presents finished output pixels under a
// valid/ready handshake. A stalled output pixel holds off operand intake.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start; a rejected start pulses cfg_error
// RUN    | accepting operand handshakes, one tap per step
// DRAIN  | all steps taken; waiting for the final output handshake
// DONE   | one-cycle done pulse, then back to IDLE
module conv_controller_cfg #(
   parameter int LOG2_OF_MEM_HEIGHT = 20,
   parameter int CNT_WIDTH          = 16,
   parameter int KS_WIDTH           = 4
) (
   input  logic                          clk,
   input  logic                          arst_n_in,
   input  logic                          start,
   input  logic                          abort,
   input  logic [CNT_WIDTH-1:0]          cfg_width,
   input  logic [CNT_WIDTH-1:0]          cfg_height,
   input  logic [CNT_WIDTH-1:0]          cfg_ch_in,
   input  logic [CNT_WIDTH-1:0]          cfg_ch_out,
   input  logic [KS_WIDTH-1:0]           cfg_kernel_size,
   output logic                          running,
   output logic                          done,
   output logic                          cfg_error,
   input  logic                          a_valid,
   input  logic                          b_valid,
   output logic                          a_ready,
   output logic                          b_ready,
   output logic                          write_a,
   output logic                          write_b,
   output logic                          mac_valid,
   output logic                          mac_accumulate_internal,
   output logic                          mac_accumulate_with_0,
   output logic                          mem_re,
   output logic [LOG2_OF_MEM_HEIGHT-1:0] mem_read_addr,
   output logic                          mem_we,
   output logic [LOG2_OF_MEM_HEIGHT-1:0] mem_write_addr,
   output logic                          output_valid,
   input  logic                          output_ready,
   output logic [CNT_WIDTH-1:0]          output_x,
   output logic [CNT_WIDTH-1:0]          output_y,
   output logic [CNT_WIDTH-1:0]          output_ch
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

   state_t state_q, state_d;

   // latched configuration
   logic [CNT_WIDTH-1:0] w_q, h_q, cin_q, cout_q;
   logic [KS_WIDTH-1:0]  k_q;

   // loop counters
   logic [CNT_WIDTH-1:0] x_q, y_q, ci_q, co_q, kv_q, kh_q;

   // MAC / memory pipeline stage
   logic                          mac_valid_q, with_0_q, internal_q, mem_we_q;
   logic [LOG2_OF_MEM_HEIGHT-1:0] mem_waddr_q;
   logic                          cfg_error_q;

   // output pixel register
   logic                 ov_q, ov_d;
   logic [CNT_WIDTH-1:0] ox_q, oy_q, och_q;

   logic cfg_ok, accept, ab_ready, step;
   logic [CNT_WIDTH-1:0] k_last;
   logic kh_wrap, kv_wrap, co_wrap, ci_wrap, y_wrap, x_wrap;
   logic c_kv, c_co, c_ci, c_y, c_x, last_step;
   logic first_tap, last_tap, out_set;

   assign cfg_ok = (cfg_width != '0) && (cfg_height != '0) && (cfg_ch_in != '0) &&
                   (cfg_ch_out != '0) && (cfg_kernel_size != '0);
   assign accept = (state_q == S_IDLE) && start && cfg_ok && !abort;

   // operands are held off only while a finished pixel waits on the consumer
   assign ab_ready = (state_q == S_RUN) && !(ov_q && !output_ready);
   assign step     = a_valid && b_valid && ab_ready;

   assign k_last  = CNT_WIDTH'(k_q) - ONE;
   assign kh_wrap = (kh_q == k_last);
   assign kv_wrap = (kv_q == k_last);
   assign co_wrap = (co_q == cout_q - ONE);
   assign ci_wrap = (ci_q == cin_q - ONE);
   assign y_wrap  = (y_q == h_q - ONE);
   assign x_wrap  = (x_q == w_q - ONE);

   // carry into each counter: all inner counters wrap on this step
   assign c_kv      = kh_wrap;
   assign c_co      = c_kv && kv_wrap;
   assign c_ci      = c_co && co_wrap;
   assign c_y       = c_ci && ci_wrap;
   assign c_x       = c_y && y_wrap;
   assign last_step = c_x && x_wrap;

   assign first_tap = (kv_q == '0) && (kh_q == '0);
   assign last_tap  = kh_wrap && kv_wrap;
   assign out_set   = step && last_tap && ci_wrap;

   // state register
   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) state_q <= S_IDLE;
      else            state_q <= state_d;
   end

   // next-state logic; abort overrides every other event
   always_comb begin
      state_d = state_q;
      if (abort) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:  if (accept) state_d = S_RUN;
            S_RUN:   if (step && last_step) state_d = S_DRAIN;
            S_DRAIN: if (ov_q && output_ready) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // output decode
   always_comb begin
      running                 = (state_q != S_IDLE);
      done                    = (state_q == S_DONE);
      cfg_error               = cfg_error_q;
      a_ready                 = ab_ready;
      b_ready                 = ab_ready;
      write_a                 = step;
      write_b                 = step;
      mac_valid               = mac_valid_q;
      mac_accumulate_with_0   = with_0_q;
      mac_accumulate_internal = internal_q;
      mem_re                  = step && first_tap && (ci_q != '0);
      mem_read_addr           = LOG2_OF_MEM_HEIGHT'(co_q);
      mem_we                  = mem_we_q;
      mem_write_addr          = mem_waddr_q;
      output_valid            = ov_q;
      output_x                = ox_q;
      output_y                = oy_q;
      output_ch               = och_q;
   end

   // cfg latch and nested loop counters
   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) begin
         w_q <= '0; h_q <= '0; cin_q <= '0; cout_q <= '0; k_q <= '0;
         x_q <= '0; y_q <= '0; ci_q <= '0; co_q <= '0; kv_q <= '0; kh_q <= '0;
      end else if (abort) begin
         x_q <= '0; y_q <= '0; ci_q <= '0; co_q <= '0; kv_q <= '0; kh_q <= '0;
      end else if (accept) begin
         w_q    <= cfg_width;
         h_q    <= cfg_height;
         cin_q  <= cfg_ch_in;
         cout_q <= cfg_ch_out;
         k_q    <= cfg_kernel_size;
         x_q <= '0; y_q <= '0; ci_q <= '0; co_q <= '0; kv_q <= '0; kh_q <= '0;
      end else if (step) begin
         kh_q <= kh_wrap ? '0 : kh_q + ONE;
         if (c_kv) kv_q <= kv_wrap ? '0 : kv_q + ONE;
         if (c_co) co_q <= co_wrap ? '0 : co_q + ONE;
         if (c_ci) ci_q <= ci_wrap ? '0 : ci_q + ONE;
         if (c_y)  y_q  <= y_wrap  ? '0 : y_q + ONE;
         if (c_x)  x_q  <= x_wrap  ? '0 : x_q + ONE;
      end
   end

   // MAC qualifiers and write-back, aligned with the registered operands
   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) begin
         mac_valid_q <= 1'b0;
         with_0_q    <= 1'b0;
         internal_q  <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_waddr_q <= '0;
         cfg_error_q <= 1'b0;
      end else begin
         mac_valid_q <= step && !abort;
         with_0_q    <= step && !abort && first_tap && (ci_q == '0);
         internal_q  <= step && !abort && !first_tap;
         mem_we_q    <= step && !abort && last_tap && !ci_wrap;
         if (step) mem_waddr_q <= LOG2_OF_MEM_HEIGHT'(co_q);
         cfg_error_q <= (state_q == S_IDLE) && start && !cfg_ok && !abort;
      end
   end

   // output pixel valid: set by a completing step, cleared on acceptance
   always_comb begin
      ov_d = ov_q;
      if (abort)             ov_d = 1'b0;
      else if (out_set)      ov_d = 1'b1;
      else if (output_ready) ov_d = 1'b0;
   end

   // output pixel register; coordinates only change when a new pixel is set
   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) begin
         ov_q  <= 1'b0;
         ox_q  <= '0;
         oy_q  <= '0;
         och_q <= '0;
      end else begin
         ov_q <= ov_d;
         if (out_set && !abort) begin
            ox_q  <= x_q;
            oy_q  <= y_q;
            och_q <= co_q;
         end
      end
   end

endmodule

// File: tb/tb_conv_controller_cfg.sv
// Directed bench for conv_controller_cfg. Expected output pixels are queued
// up front from the loop nest and popped on each output handshake; a
// software copy of the loop counters predicts the MAC/memory strobes.
module tb_conv_controller_cfg;

   localparam int AW = 20;
   localparam int CW = 16;
   localparam int KW = 4;

   logic          clk = 1'b0;
   logic          arst_n_in = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [CW-1:0] cfg_width = '0, cfg_height = '0, cfg_ch_in = '0, cfg_ch_out = '0;
   logic [KW-1:0] cfg_kernel_size = '0;
   logic          a_valid = 1'b0, b_valid = 1'b0, output_ready = 1'b0;
   logic          running, done, cfg_error, a_ready, b_ready, write_a, write_b;
   logic          mac_valid, mac_accumulate_internal, mac_accumulate_with_0;
   logic          mem_re, mem_we, output_valid;
   logic [AW-1:0] mem_read_addr, mem_write_addr;
   logic [CW-1:0] output_x, output_y, output_ch;

   conv_controller_cfg #(.LOG2_OF_MEM_HEIGHT(AW), .CNT_WIDTH(CW), .KS_WIDTH(KW)) dut (
      .clk(clk), .arst_n_in(arst_n_in), .start(start), .abort(abort),
      .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_ch_in(cfg_ch_in),
      .cfg_ch_out(cfg_ch_out), .cfg_kernel_size(cfg_kernel_size),
      .running(running), .done(done), .cfg_error(cfg_error),
      .a_valid(a_valid), .b_valid(b_valid), .a_ready(a_ready), .b_ready(b_ready),
      .write_a(write_a), .write_b(write_b), .mac_valid(mac_valid),
      .mac_accumulate_internal(mac_accumulate_internal),
      .mac_accumulate_with_0(mac_accumulate_with_0),
      .mem_re(mem_re), .mem_read_addr(mem_read_addr),
      .mem_we(mem_we), .mem_write_addr(mem_write_addr),
      .output_valid(output_valid), .output_ready(output_ready),
      .output_x(output_x), .output_y(output_y), .output_ch(output_ch)
   );

   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_miss = 0;

   typedef struct {
      int x;
      int y;
      int c;
   } coord_t;

   coord_t exp_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_miss++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One convolution: inputs change on the falling edge, outputs are
   // sampled 1 ns later (they then describe the coming rising edge).
   task automatic run_conv(input int w, input int h, input int cin, input int cout,
                           input int k, input bit tog_b, input int stall,
                           input int abort_at, input bit mid_start);
      int mx = 0, my = 0, mci = 0, mco = 0, mkv = 0, mkh = 0;
      int steps = 0, dones = 0, n_re = 0, n_we = 0, n_w0 = 0;
      bit e_mv = 0, e_w0 = 0, e_int = 0, e_we = 0;
      int e_wa = 0;
      int stall_left = 0;
      bit stalled = 0, fin = 0, aborted = 0, post_done = 0, ft, lt;
      coord_t c;

      exp_q.delete();
      for (int ix = 0; ix < w; ix++)
         for (int iy = 0; iy < h; iy++)
            for (int ic = 0; ic < cout; ic++) begin
               c.x = ix; c.y = iy; c.c = ic;
               exp_q.push_back(c);
            end

      @(negedge clk);
      cfg_width       = CW'(w);
      cfg_height      = CW'(h);
      cfg_ch_in       = CW'(cin);
      cfg_ch_out      = CW'(cout);
      cfg_kernel_size = KW'(k);
      start           = 1'b1;
      a_valid         = 1'b0;
      b_valid         = 1'b0;
      output_ready    = 1'b1;
      @(negedge clk);

      for (int cyc = 0; cyc < 3000; cyc++) begin
         start      = mid_start && (cyc == 30);
         cfg_width  = (mid_start && cyc == 30) ? CW'(5) : CW'(w);
         a_valid    = 1'b1;
         b_valid    = tog_b ? cyc[0] : 1'b1;
         if (stall > 0 && !stalled && output_valid) begin
            stall_left = stall;
            stalled    = 1'b1;
         end
         output_ready = (stall_left == 0);
         abort        = !aborted && (abort_at >= 0) && (steps == abort_at);
         #1;

         if (cyc == 0) chk("running_after_start", running, 1);
         chk("mac_valid", mac_valid, e_mv);
         chk("mac_with_0", mac_accumulate_with_0, e_w0);
         chk("mac_internal", mac_accumulate_internal, e_int);
         chk("mem_we", mem_we, e_we);
         if (e_we) chk("mem_write_addr", mem_write_addr, e_wa);
         chk("b_ready_eq_a_ready", b_ready, a_ready);
         chk("write_b_eq_write_a", write_b, write_a);
         if (mac_valid && mac_accumulate_with_0) n_w0++;
         if (mem_we) n_we++;

         if (aborted) begin
            chk("abort_running", running, 0);
            chk("abort_output_valid", output_valid, 0);
            fin = 1'b1;
         end
         if (post_done) begin
            chk("running_after_done", running, 0);
            fin = 1'b1;
         end
         if (fin) break;

         if (stall_left > 0) begin
            chk("stall_a_ready", a_ready, 0);
            chk("stall_output_x", output_x, 0);
            chk("stall_output_y", output_y, 0);
            chk("stall_output_ch", output_ch, 0);
            stall_left--;
         end
         if (!(a_valid && b_valid)) chk("lone_valid_no_step", write_a, 0);

         e_mv = 0; e_w0 = 0; e_int = 0; e_we = 0;
         if (write_a) begin
            ft = (mkv == 0) && (mkh == 0);
            lt = (mkv == k - 1) && (mkh == k - 1);
            chk("mem_re", mem_re, ft && (mci != 0));
            if (ft && mci != 0) chk("mem_read_addr", mem_read_addr, mco);
            if (mem_re) n_re++;
            e_mv  = 1;
            e_w0  = ft && (mci == 0);
            e_int = !ft;
            e_we  = lt && (mci != cin - 1);
            e_wa  = mco;
            steps++;
            mkh++;
            if (mkh == k) begin
               mkh = 0; mkv++;
               if (mkv == k) begin
                  mkv = 0; mco++;
                  if (mco == cout) begin
                     mco = 0; mci++;
                     if (mci == cin) begin
                        mci = 0; my++;
                        if (my == h) begin
                           my = 0; mx++;
                           if (mx == w) mx = 0;
                        end
                     end
                  end
               end
            end
         end else begin
            chk("mem_re_idle", mem_re, 0);
         end

         if (output_valid && output_ready) begin
            if (exp_q.size() == 0) begin
               chk("spurious_output", output_valid, 0);
            end else begin
               c = exp_q.pop_front();
               chk("output_x", output_x, c.x);
               chk("output_y", output_y, c.y);
               chk("output_ch", output_ch, c.c);
            end
         end
         if (done) begin
            dones++;
            post_done = 1'b1;
         end
         if (abort) begin
            aborted = 1'b1;
            e_mv = 0; e_w0 = 0; e_int = 0; e_we = 0;
         end
         @(negedge clk);
      end

      chk("run_terminated", fin, 1);
      abort   = 1'b0;
      a_valid = 1'b0;
      b_valid = 1'b0;
      if (!aborted) begin
         chk("step_count", steps, w * h * cin * cout * k * k);
         chk("outputs_left", exp_q.size(), 0);
         chk("done_pulses", dones, 1);
         chk("mem_re_count", n_re, w * h * cout * (cin - 1));
         chk("mem_we_count", n_we, w * h * cout * (cin - 1));
         chk("with_0_count", n_w0, w * h * cout);
      end
   endtask

   initial begin
      #12;
      chk("rst_running", running, 0);
      chk("rst_done", done, 0);
      chk("rst_cfg_error", cfg_error, 0);
      chk("rst_a_ready", a_ready, 0);
      chk("rst_mac_valid", mac_valid, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_output_valid", output_valid, 0);
      chk("rst_output_x", output_x, 0);
      @(negedge clk);
      arst_n_in = 1'b1;

      // baseline, with a start pulse (and changed cfg) mid-run that must be ignored
      run_conv(2, 2, 2, 2, 3, 1'b0, 0, -1, 1'b1);
      // b_valid toggling: same sequence, frozen counters on idle cycles
      run_conv(2, 2, 2, 2, 3, 1'b1, 0, -1, 1'b0);
      // output backpressure on the first pixel
      run_conv(2, 2, 2, 2, 3, 1'b0, 5, -1, 1'b0);
      // 1x1 kernel, three input channels
      run_conv(1, 1, 3, 1, 1, 1'b0, 0, -1, 1'b0);

      // rejected start: ch_out of zero
      @(negedge clk);
      cfg_width = 1; cfg_height = 1; cfg_ch_in = 1; cfg_ch_out = 0; cfg_kernel_size = 1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      #1;
      chk("cfg_error_pulse", cfg_error, 1);
      chk("cfg_error_running", running, 0);
      @(negedge clk);
      #1;
      chk("cfg_error_clears", cfg_error, 0);
      chk("cfg_error_still_idle", running, 0);

      // abort mid-run, then a full clean rerun
      run_conv(2, 2, 2, 2, 3, 1'b0, 0, 50, 1'b0);
      run_conv(2, 2, 2, 2, 3, 1'b0, 0, -1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
